// File: rtl/pipelined_addsub_pkg.sv
// Shared add/sub definitions: operation encodings and the signed-overflow rule,
// kept here so later ALU blocks can reuse them.
package pipelined_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Operands as seen by the adder (b already inverted for subtract).
  function automatic logic calc_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/pipelined_addsub_slice.sv
// Combinational W-bit ripple-carry adder built from per-bit full-adder cells.
module pipelined_addsub_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  logic [W:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]       = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1]   = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign co = w_c[W];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: the WIDTH-bit carry chain is cut into STAGES registered
// slices under valid/ready flow control, accepting one operation per clock.
module pipelined_addsub
  import pipelined_addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] r_c;
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];

  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_v_prev;
  logic [STAGES-1:0] w_c_prev;
  logic [STAGES-1:0] w_co;
  logic [WIDTH-1:0]  w_a_prev [STAGES];
  logic [WIDTH-1:0]  w_b_prev [STAGES];
  logic [WIDTH-1:0]  w_s_prev [STAGES];
  logic [WIDTH-1:0]  w_s_next [STAGES];
  logic [CHUNK-1:0]  w_sl_s   [STAGES];
  logic [WIDTH-1:0]  w_b_in;
  logic              w_c_in;

  assign w_b_in = (sub == OP_SUB) ? ~b : b;
  assign w_c_in = (sub == OP_ADD) ? ci : ~ci;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Stage k can move when any stage from k to the output is empty or the consumer takes a beat.
    assign w_adv[k] = out_ready | ~(&r_v[STAGES-1:k]);

    if (k == 0) begin : g_first
      assign w_v_prev[k] = in_valid;
      assign w_a_prev[k] = a;
      assign w_b_prev[k] = w_b_in;
      assign w_c_prev[k] = w_c_in;
      assign w_s_prev[k] = '0;
    end else begin : g_next
      assign w_v_prev[k] = r_v[k-1];
      assign w_a_prev[k] = r_a[k-1];
      assign w_b_prev[k] = r_b[k-1];
      assign w_c_prev[k] = r_c[k-1];
      assign w_s_prev[k] = r_s[k-1];
    end

    pipelined_addsub_slice #(.W(CHUNK)) u_slice (
      .a  (w_a_prev[k][k*CHUNK +: CHUNK]),
      .b  (w_b_prev[k][k*CHUNK +: CHUNK]),
      .ci (w_c_prev[k]),
      .s  (w_sl_s[k]),
      .co (w_co[k])
    );

    // Result bits above the current slice are still zero, so OR-ing in the new chunk is exact.
    assign w_s_next[k] = w_s_prev[k] | (WIDTH'(w_sl_s[k]) << (k * CHUNK));
  end

  assign in_ready = w_adv[0] & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_adv[k]) r_v[k] <= w_v_prev[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (w_adv[k]) begin
        r_a[k] <= w_a_prev[k];
        r_b[k] <= w_b_prev[k];
        r_s[k] <= w_s_next[k];
        r_c[k] <= w_co[k];
      end
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign s         = out_valid ? r_s[STAGES-1] : '0;
  assign co        = out_valid & r_c[STAGES-1];
  assign ovf       = out_valid & calc_ovf(r_a[STAGES-1][WIDTH-1], r_b[STAGES-1][WIDTH-1],
                                          r_s[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed and randomised checks of pipelined_addsub at 8/2, 32/4 and 32/1.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       iv8, ir8, ci8, sub8, ov8, or8, co8, ovf8;
  logic [7:0] a8, b8, s8;

  logic        iv32 [2];
  logic        ir32 [2];
  logic        ci32 [2];
  logic        sub32[2];
  logic        ov32 [2];
  logic        or32 [2];
  logic        co32 [2];
  logic        ovf32[2];
  logic [31:0] a32  [2];
  logic [31:0] b32  [2];
  logic [31:0] s32  [2];

  pipelined_addsub #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .ci(ci8),
    .sub(sub8), .out_valid(ov8), .out_ready(or8), .s(s8), .co(co8), .ovf(ovf8)
  );

  pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_dut32_s4 (
    .clk(clk), .rst(rst), .in_valid(iv32[0]), .in_ready(ir32[0]), .a(a32[0]), .b(b32[0]),
    .ci(ci32[0]), .sub(sub32[0]), .out_valid(ov32[0]), .out_ready(or32[0]), .s(s32[0]),
    .co(co32[0]), .ovf(ovf32[0])
  );

  pipelined_addsub #(.WIDTH(32), .STAGES(1)) u_dut32_s1 (
    .clk(clk), .rst(rst), .in_valid(iv32[1]), .in_ready(ir32[1]), .a(a32[1]), .b(b32[1]),
    .ci(ci32[1]), .sub(sub32[1]), .out_valid(ov32[1]), .out_ready(or32[1]), .s(s32[1]),
    .co(co32[1]), .ovf(ovf32[1])
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0]  q8   [$];
  logic [33:0] q32_0[$];
  logic [33:0] q32_1[$];
  logic [9:0]  e8;
  logic [33:0] e32;
  logic        acc;
  int          idx, lat, sent, cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference: plain integer arithmetic, range check for overflow.
  function automatic logic [33:0] model32(input logic [31:0] a, input logic [31:0] b,
                                          input logic ci, input logic sub);
    longint sa, sb, c, r;
    logic [32:0] u;
    logic        cout, ov;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c  = ci ? 64'sd1 : 64'sd0;
    if (!sub) begin
      u    = {1'b0, a} + {1'b0, b} + {32'd0, ci};
      cout = u[32];
      r    = sa + sb + c;
    end else begin
      u    = {1'b0, a} - {1'b0, b} - {32'd0, ci};
      cout = ~u[32];
      r    = sa - sb - c;
    end
    ov = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return {ov, cout, u[31:0]};
  endfunction

  // Scoreboard: compare every emitted beat against the expected queue, in order.
  always @(negedge clk) begin
    if (rst) begin
      q8.delete();
      q32_0.delete();
      q32_1.delete();
    end else begin
      if (ov8 && or8) begin
        if (q8.size() == 0) chk("dut8_spurious_emit", 1, 0);
        else begin
          e8 = q8.pop_front();
          chk("dut8_beat", {ovf8, co8, s8}, e8);
        end
      end
      if (ov32[0] && or32[0]) begin
        if (q32_0.size() == 0) chk("s4_spurious_emit", 1, 0);
        else begin
          e32 = q32_0.pop_front();
          chk("s4_beat", {ovf32[0], co32[0], s32[0]}, e32);
        end
      end
      if (ov32[1] && or32[1]) begin
        if (q32_1.size() == 0) chk("s1_spurious_emit", 1, 0);
        else begin
          e32 = q32_1.pop_front();
          chk("s1_beat", {ovf32[1], co32[1], s32[1]}, e32);
        end
      end
    end
  end

  task automatic step8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic ci,
                       input logic sub, input logic ordy, input logic [9:0] exp, output logic ac);
    @(posedge clk);
    #1;
    iv8 = v; a8 = a; b8 = b; ci8 = ci; sub8 = sub; or8 = ordy;
    #1;
    ac = v && ir8;
    if (ac) q8.push_back(exp);
  endtask

  task automatic dir8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic sub, input logic [7:0] es, input logic eco, input logic eovf);
    logic ac;
    step8(1'b1, a, b, ci, sub, 1'b1, {eovf, eco, es}, ac);
    chk({tag, "_accept"}, ac, 1);
    step8(1'b0, a, b, ci, sub, 1'b1, '0, ac);
    chk({tag, "_valid_early"}, ov8, 0);
    step8(1'b0, a, b, ci, sub, 1'b1, '0, ac);
    chk({tag, "_valid"}, ov8, 1);
    chk({tag, "_s"}, s8, es);
    chk({tag, "_co"}, co8, eco);
    chk({tag, "_ovf"}, ovf8, eovf);
  endtask

  task automatic push32(input int d, input logic [33:0] v);
    if (d == 0) q32_0.push_back(v);
    else        q32_1.push_back(v);
  endtask

  function automatic int qsize32(input int d);
    return (d == 0) ? q32_0.size() : q32_1.size();
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'h7FFF_FFFF;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #10_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    iv8 = 0; a8 = 0; b8 = 0; ci8 = 0; sub8 = 0; or8 = 1;
    for (int d = 0; d < 2; d++) begin
      iv32[d] = 0; a32[d] = 0; b32[d] = 0; ci32[d] = 0; sub32[d] = 0; or32[d] = 1;
    end

    // Reset behaviour
    repeat (3) @(posedge clk);
    #1;
    iv8 = 1'b1;
    #1;
    chk("rst_in_ready_low", ir8, 0);
    iv8 = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", ov8, 0);
    chk("rst_in_ready", ir8, 1);
    chk("rst_s", s8, 0);
    chk("rst_co_ovf", {co8, ovf8}, 0);
    chk("rst_s4_in_ready", ir32[0], 1);
    chk("rst_s1_out_valid", ov32[1], 0);

    // Directed single beats, latency 2
    dir8("t1_ff_plus_1",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    dir8("t2_7f_plus_1",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    dir8("t2_5_minus_7",   8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    dir8("t2_80_minus_1",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    dir8("t2_0_minus_0_b", 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    dir8("t2_ff_ff_c",     8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    dir8("t2_80_plus_80",  8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    dir8("t2_7f_minus_ff", 8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);

    // Back-to-back stream of 10 beats
    for (int j = 0; j < 13; j++) begin
      step8(j < 10, 8'(j), 8'(j), 1'b1, 1'b0, 1'b1, {2'b00, 8'(2 * j + 1)}, acc);
      if (j < 10) chk("t3_in_ready", acc, 1);
      chk("t3_out_valid", ov8, (j >= 2) && (j <= 11));
    end
    chk("t3_drained", q8.size(), 0);

    // Fill, stall for four cycles, release
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      step8(idx < 6, 8'(16 + idx), 8'h01, 1'b0, 1'b0, c >= 6, {2'b00, 8'(17 + idx)}, acc);
      if (c < 6) chk("t4_in_ready", ir8, c < 2);
      if (c >= 2 && c < 6) begin
        chk("t4_hold_valid", ov8, 1);
        chk("t4_hold_s", s8, 8'h11);
      end
      if (acc) idx++;
    end
    chk("t4_all_sent", idx, 6);
    chk("t4_drained", q8.size(), 0);

    // Reset with two beats in flight
    step8(1'b1, 8'h20, 8'h01, 1'b0, 1'b0, 1'b0, {2'b00, 8'h21}, acc);
    step8(1'b1, 8'h21, 8'h01, 1'b0, 1'b0, 1'b0, {2'b00, 8'h22}, acc);
    @(posedge clk);
    #1;
    rst = 1'b1; iv8 = 1'b1; a8 = 8'h40;
    #1;
    chk("t5_full_before_rst", ov8, 1);
    chk("t5_in_ready_in_rst", ir8, 0);
    @(posedge clk);
    #1;
    chk("t5_valid_after_rst", ov8, 0);
    chk("t5_s_after_rst", s8, 0);
    rst = 1'b0; iv8 = 1'b0; or8 = 1'b1;
    #1;
    chk("t5_in_ready_after_rst", ir8, 1);
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      #1;
      chk("t5_no_flushed_emit", ov8, 0);
    end

    // 32-bit configurations: latency, then random traffic against the model
    for (int d = 0; d < 2; d++) begin
      @(posedge clk);
      #1;
      iv32[d] = 1'b1; a32[d] = 32'h7FFF_FFFF; b32[d] = 32'h1; ci32[d] = 1'b0; sub32[d] = 1'b0;
      or32[d] = 1'b1;
      #1;
      chk("t6_lat_accept", ir32[d], 1);
      push32(d, model32(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0));
      lat = 0;
      do begin
        @(posedge clk);
        #1;
        iv32[d] = 1'b0;
        lat++;
      end while (!ov32[d] && lat < 10);
      chk("t6_latency", lat, (d == 0) ? 4 : 1);
      chk("t6_lat_result", {ovf32[d], co32[d], s32[d]}, {1'b1, 1'b0, 32'h8000_0000});

      sent = 0;
      cyc  = 0;
      while ((sent < 10000 || qsize32(d) != 0) && cyc < 40000) begin
        @(posedge clk);
        #1;
        iv32[d]  = (sent < 10000) && ($urandom_range(0, 3) != 0);
        a32[d]   = pick32();
        b32[d]   = pick32();
        ci32[d]  = 1'($urandom_range(0, 1));
        sub32[d] = 1'($urandom_range(0, 1));
        or32[d]  = ($urandom_range(0, 3) != 0);
        #1;
        if (iv32[d] && ir32[d]) begin
          push32(d, model32(a32[d], b32[d], ci32[d], sub32[d]));
          sent++;
        end
        cyc++;
      end
      iv32[d] = 1'b0;
      or32[d] = 1'b1;
      chk("t6_rand_sent", sent, 10000);
      chk("t6_rand_drained", qsize32(d), 0);
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
